operand_extender: RTL
=====================

# operand_extender

Parametrised operand-assembly and extension unit for the datapath. It accumulates FIELD_W-bit instruction fields into a DATA_W-bit operand register through prefix and negative-prefix operations, then emits the final operand zero- or sign-extended to DATA_W. The output sits behind a valid/ready handshake and feeds the ALU B-operand and comparison paths. It replaces the fixed 2-bit-to-16-bit zero extension.

## Interface
- DATA_W, 16, operand/result width; must be a multiple of FIELD_W.
- FIELD_W, 4, width of one instruction field.
- N (localparam), DATA_W/FIELD_W, maximum number of fields held.

- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous reset, active-low.
- in_valid  in  1  op/field present.
- in_ready  out  1  unit can accept; = !out_valid || out_ready.
- op  in  2  00 PFIX, 01 NFIX, 10 USE, 11 FLUSH.
- field  in  FIELD_W  instruction field.
- sext  in  1  USE only: 1 = sign-extend, 0 = zero-extend.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer takes result.
- result  out  DATA_W  extended operand.
- ovf  out  1  high with result when prefix bits were lost.

## Operation
- Accept = in_valid && in_ready; nothing changes on a non-accepted cycle.
- Internal state: oreg[DATA_W], cnt (0..N-1, the prefixes held), neg_pend, ovf_pend.
- PFIX: oreg <= (oreg | field) << FIELD_W, truncated to DATA_W. cnt <= min(cnt+1, N-1). If cnt == N-1 before the op, set ovf_pend.
- NFIX: oreg <= (~(oreg | field)) << FIELD_W, truncated. Set neg_pend. cnt and ovf_pend update as for PFIX.
- USE: raw = oreg | field; W = (cnt+1)*FIELD_W.
  - sext=1, neg_pend=0, W<DATA_W: result = raw sign-extended from bit W-1.
  - Otherwise: result = raw.
  - Set out_valid. ovf <= ovf_pend. Clear oreg, cnt, neg_pend and ovf_pend.
- FLUSH: clear oreg, cnt, neg_pend and ovf_pend. No output is produced.
- The output register holds result and ovf stable while out_valid && !out_ready.
- out_valid clears on a handshake unless a USE is accepted in the same cycle, in which case it stays high with the new result.

## Timing
- Reset (rst_n low at a clk edge) values: result 0, ovf 0, out_valid 0, oreg 0, cnt 0, neg_pend 0, ovf_pend 0. Reset takes priority over every op, including mid-sequence and mid-handshake.
- USE accepted at edge t: result and out_valid are visible after edge t, usable at t+1. Latency is one cycle.
- With out_ready held high, the unit sustains one USE per cycle.
- PFIX/NFIX/FLUSH produce no output.
- When out_valid=1 and out_ready=0, PFIX/NFIX/FLUSH are also stalled, because in_ready=0.
- in_ready is combinational from out_valid and out_ready. There is no combinational path from in_valid to out_valid.
- Wrap-around: cnt saturates at N-1, and further prefixes shift the oldest field out and set ovf_pend.

## Configuration
- SEXT_EN defined: sign extension operates as specified.
- SEXT_EN undefined:
  - the sext input is ignored;
  - every USE zero-extends, i.e. result = raw;
  - NFIX still produces ones in the upper bits through inversion.

## Test plan
(DATA_W=16, FIELD_W=4, SEXT_EN defined)
- USE 0x3, sext=0 -> result 0x0003, ovf 0, out_valid one cycle after accept.
- PFIX 0x1, PFIX 0x2, USE 0x3 sext=0 -> 0x0123, ovf 0; a following USE 0x4 -> 0x0004, confirming the clear.
- USE 0xA sext=1 -> 0xFFFA; USE 0xA sext=0 -> 0x000A; with SEXT_EN undefined, sext=1 -> 0x000A.
- NFIX 0x0, USE 0xF sext=1 -> 0xFFFF; NFIX 0x1, USE 0x0 -> 0xFFE0.
- PFIX 1, 2, 3, 4 then USE 5 -> 0x2345 with ovf 1; the next USE 0x6 -> ovf 0.
- Backpressure and reset:
  - USE 0x7 with out_ready=0 -> result held 0x0007, in_ready 0, and a pending PFIX is not absorbed.
  - Raising out_ready -> handshake, then PFIX accepted.
  - Asserting rst_n low after two PFIXes, then USE 0x1 -> 0x0001.

Source files
------------

// File: rtl/operand_extender.sv
// operand_extender
//
// Assembles an operand from FIELD_W-bit instruction fields. PFIX and NFIX
// shift fields into an internal register (NFIX inverts first). USE merges a
// final field and emits the operand zero- or sign-extended to DATA_W behind
// a valid/ready handshake. FLUSH discards any partial operand.
//
// Optional feature macro: SEXT_EN
//   defined   : USE with i_sext=1 sign-extends from the top held field bit
//   undefined : i_sext is ignored and every USE zero-extends
//
// Ports:
//   i_clk        rising-edge clock
//   i_rst_n      synchronous reset, active-low
//   i_in_valid   op/field present
//   o_in_ready   unit can accept (= !o_out_valid || i_out_ready)
//   i_op         00 PFIX, 01 NFIX, 10 USE, 11 FLUSH
//   i_field      instruction field
//   i_sext       USE only: 1 = sign-extend, 0 = zero-extend
//   o_out_valid  result valid
//   i_out_ready  consumer takes result
//   o_result     extended operand
//   o_ovf        high with o_result when prefix bits were lost

module operand_extender #(
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned FIELD_W = 4
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_in_valid,
   output logic               o_in_ready,
   input  logic [1:0]         i_op,
   input  logic [FIELD_W-1:0] i_field,
   input  logic               i_sext,
   output logic               o_out_valid,
   input  logic               i_out_ready,
   output logic [DATA_W-1:0]  o_result,
   output logic               o_ovf
);

   localparam int unsigned N     = DATA_W / FIELD_W;
   localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

   localparam logic [CNT_W-1:0] CntMax = CNT_W'(N - 1);

   localparam logic [1:0] OpPfix  = 2'b00;
   localparam logic [1:0] OpNfix  = 2'b01;
   localparam logic [1:0] OpUse   = 2'b10;
   localparam logic [1:0] OpFlush = 2'b11;

   logic [DATA_W-1:0] r_oreg;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_neg_pend;
   logic              r_ovf_pend;
   logic [DATA_W-1:0] r_result;
   logic              r_ovf;
   logic              r_out_valid;

   logic              w_accept;
   logic              w_at_max;
   logic [DATA_W-1:0] w_raw;
   logic [DATA_W-1:0] w_ext;

   assign o_in_ready  = !r_out_valid || i_out_ready;
   assign w_accept    = i_in_valid && o_in_ready;
   assign w_at_max    = (r_cnt == CntMax);
   assign w_raw       = r_oreg | DATA_W'(i_field);

   assign o_out_valid = r_out_valid;
   assign o_result    = r_result;
   assign o_ovf       = r_ovf;

   // Sign extension from bit (cnt+1)*FIELD_W-1. The loop stops at N-2 so a
   // full-width operand (cnt == N-1) passes through unchanged. An NFIX in the
   // sequence already produced the upper bits by inversion, so it wins.
`ifdef SEXT_EN
   always_comb begin
      w_ext = w_raw;
      if (i_sext && !r_neg_pend) begin
         for (int k = 0; k < int'(N) - 1; k++) begin
            if (r_cnt == CNT_W'(k)) begin
               for (int j = (k + 1) * int'(FIELD_W); j < int'(DATA_W); j++) begin
                  w_ext[j] = w_raw[(k + 1) * int'(FIELD_W) - 1];
               end
            end
         end
      end
   end
`else
   logic w_unused_sext;
   assign w_unused_sext = i_sext;

   always_comb begin
      w_ext = w_raw;
   end
`endif

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_oreg      <= '0;
         r_cnt       <= '0;
         r_neg_pend  <= 1'b0;
         r_ovf_pend  <= 1'b0;
         r_result    <= '0;
         r_ovf       <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         if (w_accept) begin
            unique case (i_op)
               OpPfix: begin
                  r_oreg <= w_raw << FIELD_W;
                  if (w_at_max) begin
                     r_ovf_pend <= 1'b1;
                  end else begin
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end
               OpNfix: begin
                  r_oreg     <= (~w_raw) << FIELD_W;
                  r_neg_pend <= 1'b1;
                  if (w_at_max) begin
                     r_ovf_pend <= 1'b1;
                  end else begin
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end
               OpUse: begin
                  r_result   <= w_ext;
                  r_ovf      <= r_ovf_pend;
                  r_oreg     <= '0;
                  r_cnt      <= '0;
                  r_neg_pend <= 1'b0;
                  r_ovf_pend <= 1'b0;
               end
               OpFlush: begin
                  r_oreg     <= '0;
                  r_cnt      <= '0;
                  r_neg_pend <= 1'b0;
                  r_ovf_pend <= 1'b0;
               end
               default: ;
            endcase
         end

         // A USE accepted alongside a handshake keeps valid high with new data.
         if (w_accept && (i_op == OpUse)) begin
            r_out_valid <= 1'b1;
         end else if (i_out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

endmodule
